pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised elastic pipeline register chain: DEPTH stages of WIDTH-bit data, each with a valid bit.
- Generalises the single enable/clear flop into a multi-stage datapath register with valid/ready handshake, global stall (hold) and flush (clear), bubble collapsing, and an occupancy count.
- Sits between processor pipeline stages or any producer/consumer pair that needs staged, stallable, flushable buffering.

Parameters:
- WIDTH, 32, data width in bits (>=1)
- DEPTH, 2, number of register stages (>=1; 0 is illegal)
- CLR_VALUE, 0, WIDTH-bit value loaded into every data register on reset and flush

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- flush  in  1  synchronous clear of all stages; highest synchronous priority
- stall  in  1  freeze all stages (hold current contents)
- in_valid  in  1  producer offers in_data
- in_ready  out  1  chain accepts in_data this cycle
- in_data  in  WIDTH  input word
- out_valid  out  1  stage DEPTH-1 holds a word for consumer
- out_ready  in  1  consumer accepts out_data
- out_data  out  WIDTH  data of stage DEPTH-1
- occupancy  out  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Reset (reset=0, asynchronous): all valid bits = 0, all data = CLR_VALUE, occupancy = 0, out_valid = 0, out_data = CLR_VALUE. in_ready = 0 while reset is asserted. Normal operation resumes at the first rising edge after reset returns to 1.
- Stage indexing: stage 0 is the input stage; stage DEPTH-1 drives out_data/out_valid.
- Advance rule, combinational:
  - adv[DEPTH-1] = out_ready.
  - adv[i] = !valid[i+1] || adv[i+1].
  - Empty stages collapse bubbles, so a word moves forward whenever the next stage is free or draining.
- in_ready = adv[0] || !valid[0], gated to 0 when stall or flush is 1. The ready path is combinational from out_ready through the chain.
- out_valid = valid[DEPTH-1] && !stall && !flush.
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Normal edge (flush=0, stall=0), for each stage i:
  - If stage i-1 (or the input for i=0) transfers into it: data[i] <= source, valid[i] <= 1.
  - Else if stage i is valid and advancing: valid[i] <= 0, data unchanged.
  - Else: hold.
- Stall edge (stall=1, flush=0): every valid and data register holds. No transfers occur; the out_ready value is ignored.
- Flush edge (flush=1): all valid <= 0, all data <= CLR_VALUE, regardless of stall, in_valid and out_ready. Any word presented in that cycle is dropped and not accepted.
- Latency: a word accepted at edge N with no backpressure appears with out_valid=1 after edge N+DEPTH-1, i.e. DEPTH cycles input-to-output register latency. Throughput is 1 word/cycle when out_ready is held at 1.
- Full: all DEPTH valid bits set and out_ready=0 gives in_ready=0. With out_ready=1, simultaneous accept and drain are allowed (occupancy unchanged).
- Empty: occupancy=0 gives out_valid=0 and in_ready=1 (absent stall/flush).
- occupancy is the registered popcount of valid bits, updated on the same edge as the valid bits. Range 0..DEPTH; it never wraps.
- Data in an invalid stage is don't-care, except after reset/flush, where it equals CLR_VALUE.
- Reset asserted mid-transfer: the transfer is lost; state is cleared immediately without waiting for clk.
- Word order is strictly preserved; no duplication and no loss except by flush or reset.

Test Plan:
- Reset/idle: reset=0 mid-operation with 2 words held -> immediately out_valid=0, occupancy=0, out_data=CLR_VALUE; in_ready=0 until reset=1, then 1.
- Streaming, DEPTH=2, WIDTH=32, out_ready=1: in_data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on cycles 2,3,4 with out_valid=1; occupancy steady at 2.
- Backpressure: out_ready=0, push 0xA,0xB -> occupancy=2, in_ready=0. Push 0xC with in_valid=1 and set out_ready=1 for one cycle -> 0xA drains and 0xC is accepted the same cycle; occupancy stays 2; output order is A,B,C.
- Stall: with 0x5 in stage 0 and 0x6 in stage 1, assert stall 3 cycles with in_valid=1, out_ready=1 -> in_ready=0, out_valid=0, contents and occupancy unchanged. On release, 0x6 is output first.
- Flush priority: flush=1 together with stall=1, in_valid=1 (0xF) and full chain -> next edge occupancy=0, out_valid=0, all data=CLR_VALUE, 0xF not accepted.
- Bubble collapse, DEPTH=4: one word 0x7, then in_valid=0, out_ready=0 -> word reaches stage 3 after 4 edges. Then push 0x8,0x9,0xA -> occupancy=4, in_ready=0.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// Elastic register chain: DEPTH stages of WIDTH-bit data with valid/ready handshake,
// global stall and flush, bubble collapsing and a registered occupancy count.
module pipe_reg_chain #(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       stall,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);
   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0] valid_reg;
   logic [DEPTH-1:0] valid_next;
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] load;
   logic [WIDTH-1:0] data_reg  [DEPTH];
   logic [WIDTH-1:0] data_next [DEPTH];
   logic [WIDTH-1:0] src       [DEPTH];
   logic [OCC_W-1:0] occ_reg;
   logic [OCC_W-1:0] occ_next;
   logic             move_en;

   assign move_en = !stall && !flush;

   // Ready ripples back from the consumer; an empty stage always frees its predecessor.
   always_comb begin
      adv            = '0;
      adv[DEPTH-1]   = out_ready;
      for (int i = DEPTH-2; i >= 0; i--) begin
         adv[i] = !valid_reg[i+1] || adv[i+1];
      end
   end

   assign in_ready = reset && move_en && (adv[0] || !valid_reg[0]);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign load[gi] = in_valid && in_ready;
            assign src[gi]  = in_data;
         end else begin : g_link
            assign load[gi] = valid_reg[gi-1] && adv[gi-1] && move_en;
            assign src[gi]  = data_reg[gi-1];
         end
      end
   endgenerate

   always_comb begin
      valid_next = valid_reg;
      data_next  = data_reg;
      occ_next   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (flush) begin
            valid_next[i] = 1'b0;
            data_next[i]  = CLR_VALUE;
         end else if (!stall) begin
            if (load[i]) begin
               valid_next[i] = 1'b1;
               data_next[i]  = src[i];
            end else if (valid_reg[i] && adv[i]) begin
               valid_next[i] = 1'b0;
            end
         end
         occ_next = occ_next + OCC_W'(valid_next[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_reg <= '0;
         occ_reg   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_reg[i] <= CLR_VALUE;
         end
      end else begin
         valid_reg <= valid_next;
         data_reg  <= data_next;
         occ_reg   <= occ_next;
      end
   end

   assign out_valid = valid_reg[DEPTH-1] && move_en;
   assign out_data  = data_reg[DEPTH-1];
   assign occupancy = occ_reg;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: a DEPTH=2 and a DEPTH=4 instance share stimulus and are
// checked every cycle against a word/position model plus hand-computed expectations.
module tb_pipe_reg_chain;
   localparam logic [31:0] CLR2 = 32'hDEAD_BEEF;
   localparam logic [7:0]  CLR4 = 8'h5A;

   logic        clk       = 1'b0;
   logic        reset     = 1'b0;
   logic        flush     = 1'b0;
   logic        stall     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_data   = '0;

   logic        in_ready2, out_valid2;
   logic [31:0] out_data2;
   logic [1:0]  occ2;
   logic        in_ready4, out_valid4;
   logic [7:0]  out_data4;
   logic [2:0]  occ4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pipe_reg_chain #(.WIDTH(32), .DEPTH(2), .CLR_VALUE(CLR2)) dut2 (
      .clk(clk), .reset(reset), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .occupancy(occ2)
   );

   pipe_reg_chain #(.WIDTH(8), .DEPTH(4), .CLR_VALUE(CLR4)) dut4 (
      .clk(clk), .reset(reset), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data[7:0]),
      .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
      .occupancy(occ4)
   );

   // Model: per instance, the list of words in flight (oldest first) and the stage each sits in.
   int          mcnt  [2];
   int          mpos  [2][4];
   logic [31:0] mdat  [2][4];
   bit          mmv   [2][4];
   bit          mclean[2];

   function automatic int depth_of(int p);
      return (p == 0) ? 2 : 4;
   endfunction

   function automatic logic [31:0] mask_of(int p);
      return (p == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
   endfunction

   function automatic logic [31:0] clr_of(int p);
      return (p == 0) ? CLR2 : {24'h0, CLR4};
   endfunction

   function automatic void mclear(int p);
      mcnt[p]   = 0;
      mclean[p] = 1'b1;
   endfunction

   // A word moves if the slot ahead is empty, or the word ahead moves too.
   function automatic void calc_moves(int p);
      int d = depth_of(p);
      for (int k = 0; k < mcnt[p]; k++) begin
         if (k == 0) mmv[p][k] = (mpos[p][0] < d-1) || out_ready;
         else        mmv[p][k] = (mpos[p][k] + 1 < mpos[p][k-1]) || mmv[p][k-1];
      end
   endfunction

   function automatic bit exp_in_ready(int p);
      int last = mcnt[p] - 1;
      if (!reset || stall || flush) return 1'b0;
      if (mcnt[p] == 0) return 1'b1;
      return (mpos[p][last] > 0) || mmv[p][last];
   endfunction

   function automatic bit exp_out_valid(int p);
      return (mcnt[p] > 0) && (mpos[p][0] == depth_of(p) - 1) && !stall && !flush;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare(input int p, input logic ir, input logic ov,
                          input logic [31:0] od, input logic [31:0] occ);
      bit eov;
      int d = depth_of(p);
      calc_moves(p);
      eov = exp_out_valid(p);
      chk($sformatf("dut%0d in_ready", d),  32'(ir),  32'(exp_in_ready(p)));
      chk($sformatf("dut%0d out_valid", d), 32'(ov),  32'(eov));
      chk($sformatf("dut%0d occupancy", d), occ,      32'(mcnt[p]));
      if (eov || mclean[p])
         chk($sformatf("dut%0d out_data", d), od, eov ? mdat[p][0] : clr_of(p));
   endtask

   task automatic update(input int p);
      bit acc;
      int d = depth_of(p);
      if (!reset || flush) begin
         mclear(p);
         return;
      end
      if (stall) return;
      calc_moves(p);
      acc = exp_in_ready(p) && in_valid;
      for (int k = 0; k < mcnt[p]; k++)
         if (mmv[p][k]) mpos[p][k]++;
      if (mcnt[p] > 0 && mpos[p][0] == d) begin
         $display("dut%0d deliver 0x%0h", d, mdat[p][0]);
         for (int k = 1; k < mcnt[p]; k++) begin
            mpos[p][k-1] = mpos[p][k];
            mdat[p][k-1] = mdat[p][k];
         end
         mcnt[p]--;
      end
      if (mcnt[p] > 0 && mpos[p][0] == d-1) mclean[p] = 1'b0;
      if (acc) begin
         mpos[p][mcnt[p]] = 0;
         mdat[p][mcnt[p]] = in_data & mask_of(p);
         mcnt[p]++;
         $display("dut%0d accept 0x%0h", d, in_data & mask_of(p));
      end
   endtask

   initial begin
      mclear(0);
      mclear(1);
      forever begin
         @(negedge clk);
         if (!reset) begin
            mclear(0);
            mclear(1);
         end
         compare(0, in_ready2, out_valid2, out_data2, 32'(occ2));
         compare(1, in_ready4, out_valid4, 32'(out_data4), 32'(occ4));
         @(posedge clk);
         update(0);
         update(1);
      end
   end

   task automatic drive(input bit iv, input logic [31:0] d, input bit ordy,
                        input bit st = 1'b0, input bit fl = 1'b0);
      @(posedge clk);
      #1;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      stall     = st;
      flush     = fl;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b1);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #2;
      chk("reset in_ready2",  32'(in_ready2),  32'h0);
      chk("reset out_valid2", 32'(out_valid2), 32'h0);
      chk("reset occ2",       32'(occ2),       32'h0);
      chk("reset out_data2",  out_data2,       CLR2);
      chk("reset out_data4",  32'(out_data4),  32'(CLR4));
      @(posedge clk);
      #1 reset = 1'b1;
      #1 chk("post-reset in_ready2", 32'(in_ready2), 32'h1);

      // Streaming with out_ready held high
      drive(1'b1, 32'h1, 1'b1);
      drive(1'b1, 32'h2, 1'b1);
      drive(1'b1, 32'h3, 1'b1);
      chk("stream out_data2 #1", out_data2, 32'h1);
      chk("stream occ2 #1",     32'(occ2), 32'h2);
      drive(1'b0, 32'h0, 1'b1);
      chk("stream out_data2 #2", out_data2, 32'h2);
      chk("stream occ2 #2",     32'(occ2), 32'h2);
      drive(1'b0, 32'h0, 1'b1);
      chk("stream out_data2 #3", out_data2, 32'h3);
      idle(6);

      // Backpressure: fill, then accept and drain on the same edge
      drive(1'b1, 32'hA, 1'b0);
      drive(1'b1, 32'hB, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      chk("bp occ2 full",     32'(occ2),      32'h2);
      chk("bp in_ready2 full", 32'(in_ready2), 32'h0);
      drive(1'b1, 32'hC, 1'b1);
      chk("bp in_ready2 drain", 32'(in_ready2), 32'h1);
      chk("bp out_data2 A",     out_data2,      32'hA);
      drive(1'b0, 32'h0, 1'b1);
      chk("bp out_data2 B", out_data2,  32'hB);
      chk("bp occ2 steady", 32'(occ2),  32'h2);
      drive(1'b0, 32'h0, 1'b1);
      chk("bp out_data2 C", out_data2,  32'hC);
      idle(6);

      // Stall: 0x6 in stage 1, 0x5 in stage 0
      drive(1'b1, 32'h6, 1'b0);
      drive(1'b1, 32'h5, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
         chk("stall in_ready2",  32'(in_ready2),  32'h0);
         chk("stall out_valid2", 32'(out_valid2), 32'h0);
         chk("stall occ2",       32'(occ2),       32'h2);
      end
      drive(1'b0, 32'h0, 1'b1);
      chk("stall release out_data2", out_data2, 32'h6);
      chk("stall release out_valid2", 32'(out_valid2), 32'h1);
      drive(1'b0, 32'h0, 1'b1);
      chk("stall release out_data2 second", out_data2, 32'h5);
      idle(6);

      // Flush beats stall and a concurrent input offer
      drive(1'b1, 32'h11, 1'b0);
      drive(1'b1, 32'h22, 1'b0);
      drive(1'b1, 32'hF, 1'b1, 1'b1, 1'b1);
      chk("flush in_ready2",  32'(in_ready2),  32'h0);
      chk("flush out_valid2", 32'(out_valid2), 32'h0);
      drive(1'b0, 32'h0, 1'b0);
      chk("flush occ2",      32'(occ2),       32'h0);
      chk("flush out_valid2 after", 32'(out_valid2), 32'h0);
      chk("flush out_data2", out_data2,       CLR2);
      chk("flush occ4",      32'(occ4),       32'h0);
      chk("flush out_data4", 32'(out_data4),  32'(CLR4));
      idle(3);

      // Bubble collapse on the DEPTH=4 instance
      drive(1'b1, 32'h7, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      chk("bubble out_valid4 early", 32'(out_valid4), 32'h0);
      drive(1'b1, 32'h8, 1'b0);
      chk("bubble out_valid4", 32'(out_valid4), 32'h1);
      chk("bubble out_data4",  32'(out_data4),  32'h7);
      drive(1'b1, 32'h9, 1'b0);
      drive(1'b1, 32'hA, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      chk("bubble occ4 full",     32'(occ4),      32'h4);
      chk("bubble in_ready4 full", 32'(in_ready4), 32'h0);

      // Asynchronous reset with dut2 holding two words
      chk("pre-reset occ2", 32'(occ2), 32'h2);
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("async reset out_valid2", 32'(out_valid2), 32'h0);
      chk("async reset occ2",       32'(occ2),       32'h0);
      chk("async reset out_data2",  out_data2,       CLR2);
      chk("async reset in_ready2",  32'(in_ready2),  32'h0);
      chk("async reset occ4",       32'(occ4),       32'h0);
      repeat (2) @(posedge clk);
      #1 chk("held reset in_ready2", 32'(in_ready2), 32'h0);
      @(posedge clk);
      #1 reset = 1'b1;
      #1 chk("released reset in_ready2", 32'(in_ready2), 32'h1);

      // Mixed traffic with intermittent backpressure, one stall and one flush
      for (int i = 0; i < 24; i++)
         drive((i % 3) != 2, 32'h100 + 32'(i), (i % 4) != 1, i == 10, i == 17);
      idle(6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
